// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared definitions for the RGMII transmit encoder.
//   - link speed encodings as carried on the speed input
//   - default clk cycles per RGMII clock period at 100M and 10M
//   - TXC high half-cycle counts, giving 50% duty at each speed
//   - the held MAC byte type and its idle value
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam int DEF_P100_CYCLES = 5;
    localparam int DEF_P10_CYCLES  = 50;

    // A period of P clk cycles spans 2P half-cycles, so 50% duty means the
    // first P half-cycles are high.
    localparam int TXC_HIGH_HALVES_100 = DEF_P100_CYCLES;
    localparam int TXC_HIGH_HALVES_10  = DEF_P10_CYCLES;

    typedef struct packed {
        logic [7:0] txd;
        logic       en;
        logic       er;
    } gmii_byte_t;

    localparam gmii_byte_t IDLE_BYTE = '0;

    // Both 2'b10 and 2'b11 select gigabit.
    function automatic logic is_gig(input logic [1:0] speed);
        return speed[1];
    endfunction

endpackage

// File: rtl/rgmii_txc_gen.sv
// rgmii_txc_gen: byte-period timing for the RGMII transmit encoder.
// Owns the cnt/nib counters, the registered look-ahead for the MAC byte
// strobe and the forwarded TXC half-cycle pattern.
// Ports:
//   clk, rst_n     125 MHz clock, asynchronous active-low reset
//   speed          speed in effect from the next edge on
//   restart        abort the current byte period and start again from cnt 0
//   nib_next       nibble select for the next cycle (0 = low, 1 = high)
//   clk_en         byte strobe, high in the last cycle of a byte period
//   txc_d1/txc_d2  TXC levels for the rising/falling half-cycles
module rgmii_txc_gen
    import rgmii_pkg::*;
#(
    parameter int P100_CYCLES = DEF_P100_CYCLES,
    parameter int P10_CYCLES  = DEF_P10_CYCLES,
    parameter int TXC_HI_100  = TXC_HIGH_HALVES_100,
    parameter int TXC_HI_10   = TXC_HIGH_HALVES_10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic       restart,
    output logic       nib_next,
    output logic       clk_en,
    output logic       txc_d1,
    output logic       txc_d2
);

    localparam int P_MAX = (P10_CYCLES > P100_CYCLES) ? P10_CYCLES : P100_CYCLES;
    localparam int CNT_W = $clog2(P_MAX);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic             nib;
    logic             gig;
    int               period;
    int               hi_halves;
    logic             clk_en_next, txc_d1_next, txc_d2_next;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; that is what keeps this logic free of latches.
    always_comb begin
        gig         = is_gig(speed);
        period      = (speed == SPEED_100) ? P100_CYCLES : P10_CYCLES;
        hi_halves   = (speed == SPEED_100) ? TXC_HI_100 : TXC_HI_10;
        cnt_next    = cnt;
        nib_next    = nib;
        clk_en_next = 1'b0;
        txc_d1_next = 1'b1;
        txc_d2_next = 1'b0;

        // Gigabit needs no serialisation, so the counters rest at zero there.
        if (restart || gig) begin
            cnt_next = '0;
            nib_next = 1'b0;
        end else if (cnt == CNT_W'(period - 1)) begin
            cnt_next = '0;
            nib_next = ~nib;
        end else begin
            cnt_next = cnt + 1'b1;
        end

        // Look-ahead: raise the strobe for the cycle whose counter state is
        // the last one of the byte period, so clk_en itself is a flop.
        if (restart) begin
            clk_en_next = 1'b0;
        end else if (gig) begin
            clk_en_next = 1'b1;
        end else begin
            clk_en_next = (cnt_next == CNT_W'(period - 1)) && nib_next;
        end

        // Half-cycle 2*cnt is the rising half, 2*cnt+1 the falling half.
        if (!gig) begin
            txc_d1_next = (2 * int'(cnt_next)) < hi_halves;
            txc_d2_next = (2 * int'(cnt_next) + 1) < hi_halves;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            nib    <= 1'b0;
            clk_en <= 1'b0;
            txc_d1 <= 1'b0;
            txc_d2 <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            nib    <= nib_next;
            clk_en <= clk_en_next;
            txc_d1 <= txc_d1_next;
            txc_d2 <= txc_d2_next;
        end
    end

endmodule

// File: rtl/rgmii_tx_encoder.sv
// rgmii_tx_encoder: GMII-style MAC transmit stream to RGMII DDR pin pairs.
// Every output is a flop; d1/d2 feed oddr instances (TXD width 4, TX_CTL
// and TXC width 1). 10/100M serialise each byte as two nibbles and pace
// the MAC through gmii_clk_en.
// Ports:
//   clk, rst_n             125 MHz clock, asynchronous active-low reset
//   speed                  00 = 10M, 01 = 100M, 1x = 1000M
//   gmii_txd/_tx_en/_tx_er MAC byte, consumed at the end of a gmii_clk_en cycle
//   gmii_clk_en            byte strobe to the MAC
//   txd_d1/txd_d2          TXD rising/falling half-cycle values
//   tx_ctl_d1/tx_ctl_d2    TX_CTL rising/falling half-cycle values
//   txc_d1/txc_d2          forwarded TXC rising/falling half-cycle values
module rgmii_tx_encoder
    import rgmii_pkg::*;
#(
    parameter int P100_CYCLES = DEF_P100_CYCLES,
    parameter int P10_CYCLES  = DEF_P10_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_clk_en,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       tx_ctl_d1,
    output logic       tx_ctl_d2,
    output logic       txc_d1,
    output logic       txc_d2
);

    logic [1:0] speed_reg;
    gmii_byte_t hold, hold_next;
    logic       restart;
    logic       nib_next;
    logic [3:0] txd_d1_next, txd_d2_next;

    // Any change of the speed input aborts the byte in flight.
    assign restart = (speed != speed_reg);

    // Without a restart speed equals speed_reg, so the raw input is always
    // the speed that applies from the next edge on.
    rgmii_txc_gen #(
        .P100_CYCLES (P100_CYCLES),
        .P10_CYCLES  (P10_CYCLES),
        .TXC_HI_100  (P100_CYCLES),
        .TXC_HI_10   (P10_CYCLES)
    ) u_txc_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .speed    (speed),
        .restart  (restart),
        .nib_next (nib_next),
        .clk_en   (gmii_clk_en),
        .txc_d1   (txc_d1),
        .txc_d2   (txc_d2)
    );

    always_comb begin
        hold_next = hold;
        if (restart) begin
            hold_next = IDLE_BYTE;
        end else if (gmii_clk_en) begin
            hold_next = '{txd: gmii_txd, en: gmii_tx_en, er: gmii_tx_er};
        end

        if (is_gig(speed)) begin
            txd_d1_next = hold_next.txd[3:0];
            txd_d2_next = hold_next.txd[7:4];
        end else if (nib_next) begin
            txd_d1_next = hold_next.txd[7:4];
            txd_d2_next = hold_next.txd[7:4];
        end else begin
            txd_d1_next = hold_next.txd[3:0];
            txd_d2_next = hold_next.txd[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_reg <= SPEED_1000;
            hold      <= IDLE_BYTE;
            txd_d1    <= '0;
            txd_d2    <= '0;
            tx_ctl_d1 <= 1'b0;
            tx_ctl_d2 <= 1'b0;
        end else begin
            speed_reg <= speed;
            hold      <= hold_next;
            txd_d1    <= txd_d1_next;
            txd_d2    <= txd_d2_next;
            tx_ctl_d1 <= hold_next.en;
            tx_ctl_d2 <= hold_next.en ^ hold_next.er;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_encoder.sv
// tb_rgmii_tx_encoder: randomized bench for rgmii_tx_encoder with a
// byte-period reference model (phase within the byte, current byte).
module tb_rgmii_tx_encoder;

    localparam int P100 = 5;
    localparam int P10  = 50;

    typedef struct packed {
        logic [7:0] d;
        logic       en;
        logic       er;
    } mbyte_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] speed = 2'b10;
    logic [7:0] gmii_txd = '0;
    logic       gmii_tx_en = 1'b0;
    logic       gmii_tx_er = 1'b0;
    logic       gmii_clk_en;
    logic [3:0] txd_d1, txd_d2;
    logic       tx_ctl_d1, tx_ctl_d2, txc_d1, txc_d2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [1:0] m_speed;
    int         m_phase;   // cycle index within the current byte period
    mbyte_t     m_byte;    // byte currently on the wire
    bit         m_gap;     // gigabit strobe suppressed for one cycle
    bit         m_zero;    // still showing reset values

    always #4 clk = ~clk;

    rgmii_tx_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .speed       (speed),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .gmii_clk_en (gmii_clk_en),
        .txd_d1      (txd_d1),
        .txd_d2      (txd_d2),
        .tx_ctl_d1   (tx_ctl_d1),
        .tx_ctl_d2   (tx_ctl_d2),
        .txc_d1      (txc_d1),
        .txc_d2      (txc_d2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period_of(input logic [1:0] sp);
        return (sp == 2'b01) ? P100 : P10;
    endfunction

    function automatic logic model_strobe();
        if (m_zero) return 1'b0;
        if (m_speed[1]) return !m_gap;
        return m_phase == 2 * period_of(m_speed) - 1;
    endfunction

    task automatic model_reset();
        m_speed = 2'b10;
        m_phase = 0;
        m_byte  = '0;
        m_gap   = 1'b0;
        m_zero  = 1'b1;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic strobe;
        strobe = model_strobe();
        if (speed != m_speed) begin
            m_speed = speed;
            m_phase = 0;
            m_byte  = '0;
            m_gap   = 1'b1;
        end else if (m_speed[1]) begin
            if (strobe) m_byte = '{d: gmii_txd, en: gmii_tx_en, er: gmii_tx_er};
            m_gap = 1'b0;
        end else begin
            if (strobe) m_byte = '{d: gmii_txd, en: gmii_tx_en, er: gmii_tx_er};
            m_phase = (m_phase + 1) % (2 * period_of(m_speed));
        end
        m_zero = 1'b0;
    endtask

    task automatic compare(input string where);
        logic [3:0] e_d1, e_d2;
        logic       e_c1, e_c2, e_t1, e_t2;
        int         p, c;
        if (m_zero) begin
            e_d1 = '0; e_d2 = '0; e_c1 = 0; e_c2 = 0; e_t1 = 0; e_t2 = 0;
        end else begin
            e_c1 = m_byte.en;
            e_c2 = m_byte.en ^ m_byte.er;
            if (m_speed[1]) begin
                e_d1 = m_byte.d[3:0];
                e_d2 = m_byte.d[7:4];
                e_t1 = 1'b1;
                e_t2 = 1'b0;
            end else begin
                p    = period_of(m_speed);
                c    = m_phase % p;
                e_d1 = (m_phase < p) ? m_byte.d[3:0] : m_byte.d[7:4];
                e_d2 = e_d1;
                e_t1 = (2 * c) < p;
                e_t2 = (2 * c + 1) < p;
            end
        end
        check({where, ".clk_en"}, 32'(gmii_clk_en), 32'(model_strobe()));
        check({where, ".txd"}, {24'd0, txd_d1, txd_d2}, {24'd0, e_d1, e_d2});
        check({where, ".tx_ctl"}, {30'd0, tx_ctl_d1, tx_ctl_d2}, {30'd0, e_c1, e_c2});
        check({where, ".txc"}, {30'd0, txc_d1, txc_d2}, {30'd0, e_t1, e_t2});
    endtask

    // Called at a falling edge: drive inputs, cross a rising edge, then
    // compare at the following falling edge.
    task automatic tick(input logic [1:0] sp, input logic [7:0] d, input logic e, input logic r,
                        input string where);
        speed      = sp;
        gmii_txd   = d;
        gmii_tx_en = e;
        gmii_tx_er = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare(where);
    endtask

    task automatic rand_ticks(input logic [1:0] sp, input int n, input string where);
        for (int i = 0; i < n; i++) begin
            tick(sp, 8'($urandom), 1'($urandom), 1'($urandom), where);
        end
    endtask

    initial begin
        logic [1:0] sp;
        model_reset();

        // Reset values.
        repeat (3) @(negedge clk);
        compare("reset");
        rst_n = 1'b1;

        // Gigabit: data mapping and TX_CTL encodings.
        repeat (3) tick(2'b10, 8'h5D, 1'b1, 1'b0, "gig_5d");
        repeat (2) tick(2'b10, 8'h5D, 1'b1, 1'b1, "gig_err");
        repeat (2) tick(2'b10, 8'h0F, 1'b0, 1'b1, "gig_ext");
        repeat (2) tick(2'b10, 8'h00, 1'b0, 1'b0, "gig_idle");
        rand_ticks(2'b10, 150, "gig_rand");

        // 100M: hold 0xA3 long enough to cover several byte periods.
        repeat (35) tick(2'b01, 8'hA3, 1'b1, 1'b0, "m100_a3");
        rand_ticks(2'b01, 200, "m100_rand");

        // 10M byte periods and TXC shape.
        rand_ticks(2'b00, 450, "m10_rand");

        // 100M mid-byte switch to gigabit.
        rand_ticks(2'b01, 23, "m100_pre");
        rand_ticks(2'b10, 30, "sw_gig");

        // Random speed changes, including 2'b11.
        sp = 2'b01;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) sp = 2'($urandom_range(0, 3));
            tick(sp, 8'($urandom), 1'($urandom), 1'($urandom), "spd_rand");
        end

        // 10M mid-frame, reset between edges.
        repeat (60) tick(2'b00, 8'hC6, 1'b1, 1'b0, "m10_frame");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare("async_rst");
        @(negedge clk);
        compare("rst_hold");
        rst_n = 1'b1;
        rand_ticks(2'b10, 20, "post_rst_gig");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
